// File: rtl/state_step_decoder.sv
// state_step_decoder
//
// Receiver for a 2-bit wrapping Moore-state bus (00 -> 01 -> 10 -> 11 -> 00)
// driven by a remote step FSM. The bus is resynchronised, compared against
// the last accepted value, and turned back into step events. A local step
// counter is kept and illegal jumps are reported.
//
// Optional feature: define STATE_STEP_REVERSE_EN to accept diff=3 as a legal
// backward step. This adds the output port `dir`, and err_code=10 is then
// never produced.
//
// Parameters:
//   SYNC_STAGES  synchroniser flops ahead of the capture flop (0..3)
//   CNT_W        width of step_count
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous reset, active low
//   state_in    observed remote state bus
//   clear_err   synchronous; leaves ERROR and re-arms the lock
//   count_clr   synchronous; zeroes step_count
//   locked      high while in LOCKED
//   step_pulse  one-cycle pulse per legal step
//   wrap_pulse  one-cycle pulse on a legal step across the 11/00 boundary
//   step_count  legal steps, modulo 2^CNT_W
//   err_flag    high while in ERROR
//   err_code    00 none, 01 skip (+2), 10 reverse (+3)
//   dir         (STATE_STEP_REVERSE_EN only) 1 = backward, valid with step_pulse
module state_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       state_in,
  input  logic             clear_err,
  input  logic             count_clr,
  output logic             locked,
  output logic             step_pulse,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] step_count,
  output logic             err_flag,
  output logic [1:0]       err_code
`ifdef STATE_STEP_REVERSE_EN
  ,
  output logic             dir
`endif
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    LOCKED   = 2'b01,
    ERROR    = 2'b10
  } fsm_t;

  logic [1:0] cur;
  logic       cur_valid;

  // cur_valid travels with the data so the first lock after reset uses a
  // real sample of state_in rather than the reset contents of the chain.
  if (SYNC_STAGES == 0) begin : g_nosync
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cur       <= 2'b00;
        cur_valid <= 1'b0;
      end else begin
        cur       <= state_in;
        cur_valid <= 1'b1;
      end
    end
  end else begin : g_sync
    logic [1:0]             sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] valid_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
          sync_q[i] <= 2'b00;
        end
        valid_q   <= '0;
        cur       <= 2'b00;
        cur_valid <= 1'b0;
      end else begin
        sync_q[0]  <= state_in;
        valid_q[0] <= 1'b1;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i]  <= sync_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
        cur       <= sync_q[SYNC_STAGES-1];
        cur_valid <= valid_q[SYNC_STAGES-1];
      end
    end
  end

  fsm_t             state;
  fsm_t             state_nxt;
  logic [1:0]       last;
  logic [1:0]       last_nxt;
  logic [1:0]       diff;
  logic [1:0]       err_code_nxt;
  logic             step_nxt;
  logic             wrap_nxt;
  logic [CNT_W-1:0] count_base;
  logic [CNT_W-1:0] count_nxt;
`ifdef STATE_STEP_REVERSE_EN
  logic             dir_nxt;
`endif

  // Next-state and next-output decode. count_clr only replaces the base the
  // step is applied to, so a coincident forward step lands on 1.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    err_code_nxt = err_code;
    step_nxt     = 1'b0;
    wrap_nxt     = 1'b0;
    count_base   = count_clr ? '0 : step_count;
    count_nxt    = count_base;
    diff         = cur - last;
`ifdef STATE_STEP_REVERSE_EN
    dir_nxt      = 1'b0;
`endif

    case (state)
      UNLOCKED: begin
        if (cur_valid) begin
          last_nxt  = cur;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        case (diff)
          2'd1: begin
            step_nxt  = 1'b1;
            count_nxt = count_base + CNT_W'(1);
            last_nxt  = cur;
            wrap_nxt  = (last == 2'b11);
          end
          2'd2: begin
            state_nxt    = ERROR;
            err_code_nxt = 2'b01;
            last_nxt     = cur;
          end
          2'd3: begin
`ifdef STATE_STEP_REVERSE_EN
            step_nxt  = 1'b1;
            dir_nxt   = 1'b1;
            count_nxt = count_base - CNT_W'(1);
            last_nxt  = cur;
            wrap_nxt  = (last == 2'b00);
`else
            state_nxt    = ERROR;
            err_code_nxt = 2'b10;
            last_nxt     = cur;
`endif
          end
          default: begin
          end
        endcase
      end
      ERROR: begin
        if (clear_err) begin
          state_nxt    = UNLOCKED;
          err_code_nxt = 2'b00;
        end
      end
      default: begin
        // Unused encoding: fall back to a clean relock.
        state_nxt    = UNLOCKED;
        err_code_nxt = 2'b00;
      end
    endcase
  end

  // All outputs are registered so they change together, one edge after the
  // comparison of cur with last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= UNLOCKED;
      last       <= 2'b00;
      step_count <= '0;
      err_code   <= 2'b00;
      locked     <= 1'b0;
      err_flag   <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
`ifdef STATE_STEP_REVERSE_EN
      dir        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      last       <= last_nxt;
      step_count <= count_nxt;
      err_code   <= err_code_nxt;
      locked     <= (state_nxt == LOCKED);
      err_flag   <= (state_nxt == ERROR);
      step_pulse <= step_nxt;
      wrap_pulse <= wrap_nxt;
`ifdef STATE_STEP_REVERSE_EN
      dir        <= dir_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_state_step_decoder.sv
// tb_state_step_decoder
//
// Directed bench for state_step_decoder at default parameters
// (SYNC_STAGES=2, CNT_W=8, reverse feature disabled). Expected values are
// queued with the cycle they fall due and compared when that cycle arrives.
module tb_state_step_decoder;

  localparam int S_LOCKED = 0;
  localparam int S_STEP   = 1;
  localparam int S_WRAP   = 2;
  localparam int S_COUNT  = 3;
  localparam int S_ERR    = 4;
  localparam int S_CODE   = 5;

  logic       clk;
  logic       reset;
  logic [1:0] state_in;
  logic       clear_err;
  logic       count_clr;
  logic       locked;
  logic       step_pulse;
  logic       wrap_pulse;
  logic [7:0] step_count;
  logic       err_flag;
  logic [1:0] err_code;

  state_step_decoder #(
    .SYNC_STAGES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state_in(state_in),
    .clear_err(clear_err),
    .count_clr(count_clr),
    .locked(locked),
    .step_pulse(step_pulse),
    .wrap_pulse(wrap_pulse),
    .step_count(step_count),
    .err_flag(err_flag),
    .err_code(err_code)
  );

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] exp;
    string      tag;
  } item_t;

  item_t sb[$];
  int    cycle = 0;
  int    checks_total = 0;
  int    checks_passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] observe(int sel);
    case (sel)
      S_LOCKED: return {7'd0, locked};
      S_STEP:   return {7'd0, step_pulse};
      S_WRAP:   return {7'd0, wrap_pulse};
      S_COUNT:  return step_count;
      S_ERR:    return {7'd0, err_flag};
      default:  return {6'd0, err_code};
    endcase
  endfunction

  task automatic expectAt(int delay, int sel, logic [7:0] exp, string tag);
    item_t it;
    it.due = cycle + delay;
    it.sel = sel;
    it.exp = exp;
    it.tag = tag;
    sb.push_back(it);
  endtask

  // Compare every queued expectation that falls due in the current cycle.
  task automatic checkOutput();
    item_t keep[$];
    logic [7:0] obs;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].due == cycle) begin
        obs = observe(sb[i].sel);
        checks_total++;
        assert (obs === sb[i].exp) begin
          checks_passed++;
        end else begin
          $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h",
                 sb[i].tag, cycle, obs, sb[i].exp);
        end
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    #1;
    checkOutput();
  endtask

  // Drive one legal step and queue its outcome four edges later.
  task automatic applyStimulus(logic [1:0] val, logic [7:0] cnt, logic wrap, int hold, string tag);
    state_in = val;
    expectAt(4, S_STEP, 8'd1, {tag, "_pulse"});
    expectAt(4, S_COUNT, cnt, {tag, "_count"});
    expectAt(4, S_WRAP, {7'd0, wrap}, {tag, "_wrap"});
    expectAt(5, S_STEP, 8'd0, {tag, "_pulse_end"});
    repeat (hold) tick();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    logic [1:0] val;
    reset     = 1'b0;
    state_in  = 2'b10;
    clear_err = 1'b0;
    count_clr = 1'b0;

    // Reset held for three cycles: everything quiet.
    for (int d = 1; d <= 3; d++) begin
      expectAt(d, S_LOCKED, 8'd0, "rst_locked");
      expectAt(d, S_STEP, 8'd0, "rst_step");
      expectAt(d, S_COUNT, 8'd0, "rst_count");
      expectAt(d, S_ERR, 8'd0, "rst_err");
      expectAt(d, S_CODE, 8'd0, "rst_code");
    end
    repeat (3) tick();

    // Release with 10 held: lock after SYNC_STAGES+2 edges, no step.
    reset = 1'b1;
    expectAt(3, S_LOCKED, 8'd0, "lock_early");
    expectAt(4, S_LOCKED, 8'd1, "lock_rise");
    expectAt(4, S_COUNT, 8'd0, "lock_count");
    for (int d = 1; d <= 5; d++) expectAt(d, S_STEP, 8'd0, "lock_nostep");
    repeat (5) tick();

    // Reverse 10 -> 01 is an error in the default build.
    state_in = 2'b01;
    expectAt(3, S_LOCKED, 8'd1, "rev_prelocked");
    expectAt(4, S_ERR, 8'd1, "rev_err");
    expectAt(4, S_CODE, 8'd2, "rev_code");
    expectAt(4, S_LOCKED, 8'd0, "rev_locked");
    expectAt(4, S_STEP, 8'd0, "rev_step");
    expectAt(4, S_COUNT, 8'd0, "rev_count");
    repeat (5) tick();

    // Move the bus to 00 while in ERROR, then clear and relock there.
    state_in = 2'b00;
    expectAt(4, S_ERR, 8'd1, "rev_hold_err");
    expectAt(4, S_CODE, 8'd2, "rev_hold_code");
    repeat (4) tick();
    clear_err = 1'b1;
    expectAt(1, S_ERR, 8'd0, "clr1_err");
    expectAt(1, S_CODE, 8'd0, "clr1_code");
    expectAt(1, S_LOCKED, 8'd0, "clr1_unlocked");
    expectAt(2, S_LOCKED, 8'd1, "clr1_relock");
    expectAt(2, S_COUNT, 8'd0, "clr1_count");
    tick();
    clear_err = 1'b0;
    tick();

    // Legal sequence from 00, one wrap on 11 -> 00.
    applyStimulus(2'b01, 8'd1, 1'b0, 3, "seq1");
    applyStimulus(2'b10, 8'd2, 1'b0, 3, "seq2");
    applyStimulus(2'b11, 8'd3, 1'b0, 3, "seq3");
    applyStimulus(2'b00, 8'd4, 1'b1, 3, "seq4");
    applyStimulus(2'b01, 8'd5, 1'b0, 3, "seq5");

    // Skip 01 -> 11.
    state_in = 2'b11;
    expectAt(4, S_ERR, 8'd1, "skip_err");
    expectAt(4, S_CODE, 8'd1, "skip_code");
    expectAt(4, S_LOCKED, 8'd0, "skip_locked");
    expectAt(4, S_STEP, 8'd0, "skip_step");
    expectAt(4, S_COUNT, 8'd5, "skip_count");
    repeat (3) tick();
    state_in = 2'b00;
    expectAt(4, S_STEP, 8'd0, "err_nostep");
    expectAt(4, S_WRAP, 8'd0, "err_nowrap");
    expectAt(4, S_COUNT, 8'd5, "err_frozen");
    expectAt(4, S_CODE, 8'd1, "err_code_hold");
    repeat (4) tick();
    clear_err = 1'b1;
    expectAt(1, S_ERR, 8'd0, "clr2_err");
    expectAt(1, S_CODE, 8'd0, "clr2_code");
    expectAt(2, S_LOCKED, 8'd1, "clr2_relock");
    expectAt(2, S_COUNT, 8'd5, "clr2_count");
    tick();
    clear_err = 1'b0;
    tick();

    // Count clear colliding with a legal step, then count clear alone.
    applyStimulus(2'b01, 8'd6, 1'b0, 3, "pre6");
    applyStimulus(2'b10, 8'd7, 1'b0, 3, "pre7");
    state_in = 2'b11;
    expectAt(4, S_STEP, 8'd1, "coll_step");
    expectAt(4, S_COUNT, 8'd1, "coll_count");
    repeat (3) tick();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
    expectAt(1, S_COUNT, 8'd1, "coll_hold");
    tick();
    count_clr = 1'b1;
    expectAt(1, S_COUNT, 8'd0, "clr_alone");
    expectAt(1, S_STEP, 8'd0, "clr_alone_step");
    tick();
    count_clr = 1'b0;
    tick();

    // 257 legal steps: counter wraps 255 -> 0 and ends at 1.
    for (int i = 1; i <= 257; i++) begin
      val = 2'((i - 1) % 4);
      applyStimulus(val, 8'(i), (val == 2'b00), 2, $sformatf("wrap%0d", i));
    end
    drain();

    // Reset asserted between clock edges with a step in flight.
    state_in = 2'b01;
    tick();
    tick();
    #3;
    reset = 1'b0;
    #1;
    expectAt(0, S_LOCKED, 8'd0, "arst_locked");
    expectAt(0, S_COUNT, 8'd0, "arst_count");
    expectAt(0, S_STEP, 8'd0, "arst_step");
    expectAt(0, S_ERR, 8'd0, "arst_err");
    expectAt(0, S_CODE, 8'd0, "arst_code");
    expectAt(0, S_WRAP, 8'd0, "arst_wrap");
    checkOutput();
    for (int d = 1; d <= 3; d++) begin
      expectAt(d, S_STEP, 8'd0, "arst_hold_step");
      expectAt(d, S_COUNT, 8'd0, "arst_hold_count");
    end
    repeat (3) tick();
    reset = 1'b1;
    drain();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
